gin_bus_ctrl: RTL and testbench

//  Bus-side (transmitter) end of the BUS_IF protocol; the multicasters sit on the other end.
//  - Accepts a tagged command stream from the array scheduler.
//  - Broadcasts each ifmap/fltr/psum word to the multicasters with caster_en/bus_ready/bus_tag.
//  - Waits for the multicaster acknowledge (bus_valid).
//  - Returns the psum captured on psum transfers, and holds kernel_size for the array.

---
 rtl/gin_bus_ctrl_pkg.sv | 28 ++
 rtl/gin_psum_out_reg.sv | 31 +++
 rtl/gin_bus_ctrl.sv | 114 +++++++++++
 tb/tb_gin_bus_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gin_bus_ctrl_pkg.sv
// Shared types and constants for the GIN bus-side controller.
// Command types, state names and caster enable codes.
package gin_bus_ctrl_pkg;

  typedef enum logic [1:0] {T_IFMAP, T_FLTR, T_PSUM, T_CFG} bus_type_e;
  typedef enum {IDLE, ISSUE} gin_state_e;

  localparam logic [2:0] CEN_IFMAP = 3'b001;
  localparam logic [2:0] CEN_FLTR  = 3'b010;
  localparam logic [2:0] CEN_PSUM  = 3'b100;

  // The state register is a single bit; these keep the names tied to the enum.
  localparam logic S_IDLE  = 1'(int'(IDLE));
  localparam logic S_ISSUE = 1'(int'(ISSUE));

  function automatic logic [2:0] cen_of(input logic [1:0] t);
    logic [2:0] c;
    c = 3'b000;
    case (t)
      T_IFMAP: c = CEN_IFMAP;
      T_FLTR:  c = CEN_FLTR;
      T_PSUM:  c = CEN_PSUM;
      default: c = 3'b000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/gin_psum_out_reg.sv
// One-entry valid/ready holding register for psums returned from the multicasters.
module gin_psum_out_reg #(
  parameter int W     = 32,
  parameter int TAG_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [W-1:0]     load_data,
  input  logic [TAG_W-1:0] load_tag,
  input  logic             m_ready,
  output logic             m_valid,
  output logic [W-1:0]     m_data,
  output logic [TAG_W-1:0] m_tag
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_tag   <= '0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_data  <= load_data;
      m_tag   <= load_tag;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/gin_bus_ctrl.sv
// Bus-side transmitter of the BUS_IF protocol: broadcasts tagged words to the
// multicasters, waits for their acknowledge and returns captured psums.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | ready for a command (when no psum is blocking the output)
//   ISSUE   | transfer presented on bus, waiting for bus_valid or timeout
module gin_bus_ctrl
  import gin_bus_ctrl_pkg::*;
#(
  parameter  int DATA_WIDTH = 16,
  parameter  int NUM_COL    = 4,
  parameter  int TIMEOUT    = 255,
  localparam int TAG_W      = (NUM_COL > 1) ? $clog2(NUM_COL) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [1:0]              s_type,
  input  logic [TAG_W-1:0]        s_tag,
  input  logic [2*DATA_WIDTH-1:0] s_data,
  output logic [DATA_WIDTH-1:0]   ifmap_data_B2M,
  output logic [DATA_WIDTH-1:0]   fltr_data_B2M,
  output logic [2*DATA_WIDTH-1:0] psum_data_B2M,
  output logic [2:0]              caster_en,
  output logic                    bus_ready,
  output logic [TAG_W-1:0]        bus_tag,
  output logic [7:0]              kernel_size,
  input  logic                    bus_valid,
  input  logic [2*DATA_WIDTH-1:0] psum_data_M2B,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [2*DATA_WIDTH-1:0] m_data,
  output logic [TAG_W-1:0]        m_tag,
  output logic                    err_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic             state;
  logic [CNT_W-1:0] wait_cnt;
  logic             accept;
  logic             done;
  logic             psum_load;

  assign s_ready   = rst_n && (state == S_IDLE) && (!m_valid || m_ready);
  assign accept    = s_valid && s_ready;
  // The ack is checked before the terminal count, so a late ack still wins.
  assign done      = bus_valid || (wait_cnt == CNT_W'(TIMEOUT));
  assign psum_load = (state == S_ISSUE) && bus_valid && (caster_en == CEN_PSUM);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      wait_cnt       <= '0;
      ifmap_data_B2M <= '0;
      fltr_data_B2M  <= '0;
      psum_data_B2M  <= '0;
      caster_en      <= 3'b000;
      bus_ready      <= 1'b0;
      bus_tag        <= '0;
      kernel_size    <= 8'h00;
      err_timeout    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (s_type)
              T_IFMAP: ifmap_data_B2M <= s_data[DATA_WIDTH-1:0];
              T_FLTR:  fltr_data_B2M  <= s_data[DATA_WIDTH-1:0];
              T_PSUM:  psum_data_B2M  <= s_data;
              default: kernel_size    <= s_data[7:0];
            endcase
            if (s_type != T_CFG) begin
              state     <= S_ISSUE;
              caster_en <= cen_of(s_type);
              bus_tag   <= s_tag;
              bus_ready <= 1'b1;
              wait_cnt  <= CNT_W'(1);
            end
          end
        end
        S_ISSUE: begin
          if (done) begin
            state     <= S_IDLE;
            bus_ready <= 1'b0;
            caster_en <= 3'b000;
            if (!bus_valid) err_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  gin_psum_out_reg #(
    .W     (2*DATA_WIDTH),
    .TAG_W (TAG_W)
  ) u_psum_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (psum_load),
    .load_data (psum_data_M2B),
    .load_tag  (bus_tag),
    .m_ready   (m_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_tag     (m_tag)
  );

endmodule

// File: tb/tb_gin_bus_ctrl.sv
// Bench for gin_bus_ctrl: transaction-level model compared every cycle, plus
// directed scenarios with literal expectations.
module tb_gin_bus_ctrl;

  localparam int DW = 16;
  localparam int TW = 2;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [1:0]    s_type = 2'd0;
  logic [TW-1:0] s_tag = '0;
  logic [31:0]   s_data = '0;
  logic [15:0]   ifmap_data_B2M, fltr_data_B2M;
  logic [31:0]   psum_data_B2M;
  logic [2:0]    caster_en;
  logic          bus_ready;
  logic [TW-1:0] bus_tag;
  logic [7:0]    kernel_size;
  logic          bus_valid = 1'b0;
  logic [31:0]   psum_data_M2B = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [31:0]   m_data;
  logic [TW-1:0] m_tag;
  logic          err_timeout;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gin_bus_ctrl #(.DATA_WIDTH(DW), .NUM_COL(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_type(s_type), .s_tag(s_tag), .s_data(s_data),
    .ifmap_data_B2M(ifmap_data_B2M), .fltr_data_B2M(fltr_data_B2M),
    .psum_data_B2M(psum_data_B2M), .caster_en(caster_en),
    .bus_ready(bus_ready), .bus_tag(bus_tag), .kernel_size(kernel_size),
    .bus_valid(bus_valid), .psum_data_M2B(psum_data_M2B),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_tag(m_tag),
    .err_timeout(err_timeout)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a transfer is "presented" for some number of
  // cycles and ends on ack or after TO presented cycles.
  bit          model_on = 0;
  bit          mb_busy;
  int          mb_pres;
  logic [1:0]  mb_type;
  logic [TW-1:0] e_tag;
  logic [15:0] e_ifmap, e_fltr;
  logic [31:0] e_psum;
  logic [7:0]  e_kernel;
  logic        e_err, e_mv;
  logic [31:0] e_md;
  logic [TW-1:0] e_mt;

  always @(posedge clk) begin
    bit acc;
    if (!rst_n) begin
      model_on = 1; mb_busy = 0; mb_pres = 0; mb_type = 0; e_tag = 0;
      e_ifmap = 0; e_fltr = 0; e_psum = 0; e_kernel = 0; e_err = 0;
      e_mv = 0; e_md = 0; e_mt = 0;
    end else begin
      acc = s_valid && !mb_busy && (!e_mv || m_ready);
      if (e_mv && m_ready) e_mv = 0;
      if (mb_busy) begin
        mb_pres++;
        if (bus_valid) begin
          mb_busy = 0;
          if (mb_type == 2'd2) begin e_mv = 1; e_md = psum_data_M2B; e_mt = e_tag; end
        end else if (mb_pres == TO) begin
          mb_busy = 0; e_err = 1;
        end
      end else if (acc) begin
        if (s_type == 2'd3) e_kernel = s_data[7:0];
        else begin
          mb_busy = 1; mb_pres = 0; mb_type = s_type; e_tag = s_tag;
          if (s_type == 2'd0) e_ifmap = s_data[15:0];
          else if (s_type == 2'd1) e_fltr = s_data[15:0];
          else e_psum = s_data;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("s_ready",     64'(s_ready),     64'(rst_n && !mb_busy && (!e_mv || m_ready)));
      chk("bus_ready",   64'(bus_ready),   64'(mb_busy));
      chk("caster_en",   64'(caster_en),   mb_busy ? 64'(3'b001 << mb_type) : 64'd0);
      chk("bus_tag",     64'(bus_tag),     64'(e_tag));
      chk("ifmap_B2M",   64'(ifmap_data_B2M), 64'(e_ifmap));
      chk("fltr_B2M",    64'(fltr_data_B2M),  64'(e_fltr));
      chk("psum_B2M",    64'(psum_data_B2M),  64'(e_psum));
      chk("kernel_size", 64'(kernel_size), 64'(e_kernel));
      chk("err_timeout", 64'(err_timeout), 64'(e_err));
      chk("m_valid",     64'(m_valid),     64'(e_mv));
      if (e_mv) begin
        chk("m_data", 64'(m_data), 64'(e_md));
        chk("m_tag",  64'(m_tag),  64'(e_mt));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [1:0] t, input logic [TW-1:0] tg, input logic [31:0] d);
    s_valid = 1'b1; s_type = t; s_tag = tg; s_data = d;
    tick();
    s_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tick(); tick(); tick();
    chk("rst bus_ready", 64'(bus_ready), 64'd0);
    chk("rst caster_en", 64'(caster_en), 64'd0);
    chk("rst kernel",    64'(kernel_size), 64'd0);
    chk("rst m_valid",   64'(m_valid), 64'd0);
    chk("rst err",       64'(err_timeout), 64'd0);
    chk("rst s_ready",   64'(s_ready), 64'd0);
    rst_n = 1'b1;
    tick();

    // cfg
    cmd(2'd3, 2'd0, 32'h0000_0003);
    chk("cfg kernel", 64'(kernel_size), 64'd3);
    chk("cfg bus_ready", 64'(bus_ready), 64'd0);

    // ifmap, ack in the third presented cycle
    cmd(2'd0, 2'd2, 32'h0000_1234);
    for (int i = 1; i <= 3; i++) begin
      chk("ifm bus_ready", 64'(bus_ready), 64'd1);
      chk("ifm caster_en", 64'(caster_en), 64'h1);
      chk("ifm bus_tag",   64'(bus_tag), 64'd2);
      chk("ifm s_ready",   64'(s_ready), 64'd0);
      chk("ifm data",      64'(ifmap_data_B2M), 64'h1234);
      if (i == 3) bus_valid = 1'b1;
      tick();
    end
    bus_valid = 1'b0;
    chk("ifm done bus_ready", 64'(bus_ready), 64'd0);
    chk("ifm done caster_en", 64'(caster_en), 64'd0);

    // psum with returned value held while m_ready is low
    cmd(2'd2, 2'd1, 32'h1111_2222);
    bus_valid = 1'b1; psum_data_M2B = 32'hDEAD_BEEF;
    tick();
    bus_valid = 1'b0;
    chk("psum m_valid", 64'(m_valid), 64'd1);
    chk("psum m_data",  64'(m_data), 64'hDEAD_BEEF);
    chk("psum m_tag",   64'(m_tag), 64'd1);
    chk("psum s_ready", 64'(s_ready), 64'd0);
    tick(); tick();
    chk("psum hold m_valid", 64'(m_valid), 64'd1);
    chk("psum hold s_ready", 64'(s_ready), 64'd0);
    s_valid = 1'b1; s_type = 2'd2; s_tag = 2'd3; s_data = 32'h0000_0005; m_ready = 1'b1;
    #1;
    chk("drain s_ready", 64'(s_ready), 64'd1);
    tick();
    s_valid = 1'b0; m_ready = 1'b0;
    chk("drain m_valid",   64'(m_valid), 64'd0);
    chk("drain caster_en", 64'(caster_en), 64'h4);
    chk("drain bus_tag",   64'(bus_tag), 64'd3);
    chk("drain psum_B2M",  64'(psum_data_B2M), 64'd5);
    bus_valid = 1'b1; psum_data_M2B = 32'h0000_CAFE;
    tick();
    bus_valid = 1'b0;
    chk("psum2 m_data", 64'(m_data), 64'hCAFE);
    chk("psum2 m_tag",  64'(m_tag), 64'd3);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("psum2 drained", 64'(m_valid), 64'd0);

    // timeout with no ack
    cmd(2'd1, 2'd0, 32'h0000_ABCD);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus_ready) n++;
      tick();
    end
    chk("to ready cycles", 64'(n), 64'd4);
    chk("to err", 64'(err_timeout), 64'd1);
    tick(); tick();
    chk("to err sticky", 64'(err_timeout), 64'd1);

    // reset in the middle of a transfer
    cmd(2'd0, 2'd1, 32'h0000_5555);
    tick();
    chk("mid bus_ready", 64'(bus_ready), 64'd1);
    rst_n = 1'b0;
    tick();
    chk("mid rst bus_ready", 64'(bus_ready), 64'd0);
    chk("mid rst caster_en", 64'(caster_en), 64'd0);
    chk("mid rst bus_tag",   64'(bus_tag), 64'd0);
    chk("mid rst ifmap",     64'(ifmap_data_B2M), 64'd0);
    chk("mid rst kernel",    64'(kernel_size), 64'd0);
    chk("mid rst err",       64'(err_timeout), 64'd0);
    rst_n = 1'b1;
    tick();

    // ack on the same cycle the counter reaches TIMEOUT
    cmd(2'd1, 2'd2, 32'h0000_0F0F);
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) bus_valid = 1'b1;
      tick();
    end
    bus_valid = 1'b0;
    chk("late ack bus_ready", 64'(bus_ready), 64'd0);
    chk("late ack err",       64'(err_timeout), 64'd0);
    chk("late ack fltr",      64'(fltr_data_B2M), 64'h0F0F);

    // back-to-back fltr commands with ack held high
    s_valid = 1'b1; s_type = 2'd1; s_tag = 2'd1; s_data = 32'h0000_0077; bus_valid = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (s_ready) n++;
      tick();
    end
    s_valid = 1'b0; bus_valid = 1'b0;
    chk("b2b accepts", 64'(n), 64'd4);
    tick(); tick();
    chk("b2b err", 64'(err_timeout), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
